// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter pacing one serial bit; tick marks the terminal count and
// the counter reloads itself there so consecutive bits never drift.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);
    assign tick   = en && w_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_MAX;
        end else if (load || tick) begin
            r_cnt <= CNT_MAX;
        end else if (en) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO read port and serializes each as start, data (LSB first),
// optional parity and stop bits. Line outputs are registered one cycle behind the state.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DSIZE        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic                   tx_en,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    output logic                   txd,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam int unsigned IDX_W   = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam logic        PAR_INV = (PARITY == PAR_ODD);

    tx_state_e              r_state;
    tx_state_e              w_state_d;
    logic [DSIZE-1:0]       r_shift;
    logic [IDX_W-1:0]       r_bit_idx;
    logic                   r_par;
    logic                   r_rinc;
    logic                   r_txd;
    logic                   r_busy;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic w_tick;
    logic w_pop;
    logic w_line;
    logic w_can_pop;
    logic w_last_bit;
    logic w_frame_done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk (rclk),
        .rst (rrst),
        .load(w_pop),
        .en  (r_state != StIdle),
        .tick(w_tick)
    );

    assign w_can_pop    = tx_en && !rempty;
    assign w_last_bit   = (r_bit_idx == IDX_W'(DSIZE - 1));
    assign w_frame_done = (r_state == StStop) && w_tick;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        w_line    = 1'b1;
        unique case (r_state)
            StIdle: begin
                if (w_can_pop) begin
                    w_pop     = 1'b1;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_line = 1'b0;
                if (w_tick) w_state_d = StData;
            end
            StData: begin
                w_line = r_shift[0];
                if (w_tick && w_last_bit) begin
                    w_state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                end
            end
            StParity: begin
                w_line = r_par ^ PAR_INV;
                if (w_tick) w_state_d = StStop;
            end
            StStop: begin
                // Last stop cycle may chain straight into the next frame.
                if (w_tick) begin
                    if (w_can_pop) begin
                        w_pop     = 1'b1;
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_par       <= 1'b0;
            r_rinc      <= 1'b0;
            r_txd       <= 1'b1;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_rinc <= w_pop;
            r_txd  <= w_line;
            r_busy <= (r_state != StIdle);
            if (w_pop) begin
                r_shift   <= rdata;
                r_bit_idx <= '0;
                r_par     <= 1'b0;
            end else if ((r_state == StData) && w_tick) begin
                r_shift   <= r_shift >> 1;
                r_par     <= r_par ^ r_shift[0];
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign rinc      = r_rinc;
    assign txd       = r_txd;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side drainer for the dual-clock FIFO: lives entirely in the read clock domain and consumes words through the FIFO's `rempty`/`rinc`/`rdata` read port. Each popped word is serialized onto a single UART-style line: start bit, DSIZE data bits LSB first, optional parity, one stop bit. It is the transmitter counterpart to the FIFO's write-side producer and turns buffered parallel data into a paced serial stream.

## Interface
Parameters:
- `DSIZE`, 8: data word width; must match the FIFO's `DSIZE`.
- `CLKS_PER_BIT`, 16: `rclk` cycles per serial bit; legal range 2..65535.
- `PARITY`, 0: parity mode; 0 = none, 1 = even, 2 = odd.

Ports (single clock; reset is asynchronous and active-high):
- `rclk`, input, 1: read-domain clock, shared with the FIFO read side.
- `rrst`, input, 1: reset; asynchronous, active-high.
- `tx_en`, input, 1: when high, the block may pop new words.
- `rempty`, input, 1: FIFO empty flag (registered in the FIFO).
- `rdata`, input, DSIZE: FIFO head word; valid whenever `rempty`=0.
- `rinc`, output, 1: pop strobe; one cycle wide per word.
- `txd`, output, 1: serial line; idle level is 1.
- `busy`, output, 1: high while a frame is on the line.
- `frame_cnt`, output, 16: count of frames completed since reset.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Condition: `tx_en`=1 and `rempty`=0.
  - Actions in that cycle: latch `rdata` into the shift register, assert `rinc` for exactly this cycle, load the bit timer, go to START.
- START: `txd`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Shift out DSIZE bits, LSB first, CLKS_PER_BIT cycles each.
  - A 3..log2 bit index counts the bits.
  - After the last bit, go to PARITY if PARITY≠0, else STOP.
- PARITY: `txd` = XOR of the data bits (even mode) or its inverse (odd mode), for CLKS_PER_BIT cycles.
- STOP:
  - `txd`=1 for CLKS_PER_BIT cycles.
  - In the last STOP cycle, `frame_cnt` increments by 1.
  - In that same cycle, if `tx_en`=1 and `rempty`=0, load and pop directly and go to START with no idle gap. Otherwise go to IDLE.
- `rinc` is never asserted while `rempty`=1, and never in two consecutive cycles. Frame length ≥ 20 cycles guarantees the FIFO's registered `rempty` is fresh at the next pop.
- `tx_en` deasserted mid-frame: the current frame completes normally, and no further pop occurs.
- `frame_cnt` wraps from 0xFFFF to 0x0000.
- `rrst` asserted at any time, including mid-frame:
  - State goes to IDLE immediately (asynchronously).
  - `txd`=1, `rinc`=0, `busy`=0, `frame_cnt`=0.
  - The in-flight word is discarded and is not re-popped.

## Timing
- Reset values: `txd`=1, `rinc`=0, `busy`=0, `frame_cnt`=0, state IDLE. All outputs are registered.
- Pop latency: with `rempty` low at edge N in IDLE, `rinc`=1 during cycle N and `txd` falls to 0 at edge N+1.
- `busy` rises together with `txd` at the start bit. It falls one cycle after the last STOP cycle, unless a back-to-back frame starts.
- Frame duration is (10 + (PARITY≠0)) × CLKS_PER_BIT cycles for DSIZE=8.
- Back-to-back `rinc` pulses are exactly one frame duration apart.
- The bit timer counts CLKS_PER_BIT-1 down to 0 and advances the bit on 0. It has no drift across frames.

## Structure
- Package `fifo_uart_pkg` holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - the parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2);
  - the `frame_cnt` width constant (16).
- Sub-module `uart_bit_timer`: a loadable down-counter of width $clog2(CLKS_PER_BIT). It has inputs `load` and `en`, and a `tick` output that is high on the terminal count.
- The top level contains the FSM, shift register, bit index, parity accumulator and frame counter.

## Test plan
- Reset: hold `rrst`=1 with `rempty`=0 → `txd`=1, `rinc`=0, `busy`=0, `frame_cnt`=0 throughout; no pop.
- Single word (CLKS_PER_BIT=4, PARITY=0, `rdata`=0xA5, `rempty` low for one frame):
  - exactly one `rinc` pulse;
  - `txd` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - `frame_cnt`=1 afterwards.
- Back-to-back words 0x01 then 0x02 (`rempty` stays low): two `rinc` pulses exactly 40 cycles apart; stop bit of frame 1 is followed immediately by the start bit of frame 2; `frame_cnt`=2.
- `tx_en`:
  - `tx_en`=0 with `rempty`=0 → no `rinc`, `txd`=1.
  - Deassert `tx_en` during the DATA phase → frame completes, then IDLE, with no second pop.
- Async reset mid-frame: assert `rrst` during bit 3 of 0x5A → `txd`=1 with no clock edge needed. After release with `rempty`=0, the next frame carries the new head word.
- Parity, CLKS_PER_BIT=4, word 0x07:
  - PARITY=1 → parity bit 1;
  - PARITY=2 → parity bit 0;
  - frame is 44 cycles in both cases.
